// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data RAM (dmem) between two requesters:
//   port 0 = control_unit, port 1 = debug/loader.
// Ownership is round-robin. A tenure lasts at most MAX_BURST accesses while
// the other port is waiting, so neither side starves. Read data returns on the
// rvalid/rdata pair of the port that issued the read, even if ownership has
// moved on by the time the RAM answers.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   req0/req1      port n requests the RAM; held high while it has accesses
//   we0/we1        port n access is a write (1) or a read (0)
//   addr0/addr1    port n address
//   wdata0/wdata1  port n write data
//   gnt0/gnt1      port n owns the RAM this cycle (decoded from state register)
//   rvalid0/1      read data for port n is valid this cycle
//   rdata0/1       ram_dout while rvalidn, otherwise 0
//   ram_we         to dmem write enable
//   ram_addr       to dmem address
//   ram_din        to dmem write data
//   ram_dout       from dmem read data (RD_LAT cycles after the address)
//   busy           arbiter is not idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Burst counter only needs to reach MAX_BURST-1; keep at least one bit.
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state_reg, state_next;
    logic             last_reg, last_next;   // port that owned the RAM most recently
    logic [CNT_W-1:0] cnt_reg, cnt_next;     // issues made in the current tenure

    logic issue0, issue1, rd_issue;
    logic own_port, own_req, other_req;
    state_t other_state;

    // ------------------------------------------------------------------
    // Access issue decode
    // ------------------------------------------------------------------
    assign gnt0   = (state_reg == OWN0);
    assign gnt1   = (state_reg == OWN1);
    assign busy   = (state_reg != IDLE);

    // A non-owner's inputs never reach the RAM: issue requires the grant.
    assign issue0   = gnt0 & req0;
    assign issue1   = gnt1 & req1;
    assign rd_issue = (issue0 & ~we0) | (issue1 & ~we1);

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (issue0) begin
            ram_we   = we0;
            ram_addr = addr0;
            ram_din  = wdata0;
        end else if (issue1) begin
            ram_we   = we1;
            ram_addr = addr1;
            ram_din  = wdata1;
        end
    end

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    // Owner-relative views so OWN0 and OWN1 share one set of transition rules.
    assign own_port    = (state_reg == OWN1);
    assign own_req     = own_port ? req1 : req0;
    assign other_req   = own_port ? req0 : req1;
    assign other_state = own_port ? OWN0 : OWN1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;      // port 0 wins the first contest
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = last_reg ? OWN0 : OWN1;
                end else if (req0) begin
                    state_next = OWN0;
                end else if (req1) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    // Owner is done: hand over directly (no bubble) or go idle.
                    state_next = other_req ? other_state : IDLE;
                    last_next  = own_port;
                    cnt_next   = '0;
                end else if ((cnt_reg == CNT_LAST) && other_req) begin
                    // own_req high here means this cycle is an issue; it is
                    // the last access of the tenure.
                    state_next = other_state;
                    last_next  = own_port;
                    cnt_next   = '0;
                end else if (cnt_reg != CNT_LAST) begin
                    // Saturate at the limit so a later request from the other
                    // port forces a handover on the very next issue.
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read tag pipeline: RD_LAT stages of {valid, port}, aligned with the
    // RAM's read latency so the returning data is steered to its issuer.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] tag_valid_reg, tag_valid_next;
    logic [RD_LAT-1:0] tag_port_reg,  tag_port_next;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = rd_issue;
                assign tag_port_next[gi]  = issue1;
            end else begin : g_shift
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_port_next[gi]  = tag_port_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;    // drops reads in flight
            tag_port_reg  <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_port_reg  <= tag_port_next;
        end
    end

    assign rvalid0 = tag_valid_reg[RD_LAT-1] & ~tag_port_reg[RD_LAT-1];
    assign rvalid1 = tag_valid_reg[RD_LAT-1] &  tag_port_reg[RD_LAT-1];
    assign rdata0  = rvalid0 ? ram_dout : '0;
    assign rdata1  = rvalid1 ? ram_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a behavioural single-port RAM
// (registered read, read-first) attached to the ram_* pins. Inputs change
// 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Cycle numbers in the comments count from the first edge after reset release.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_we;
    logic [7:0] ram_addr, ram_din, ram_dout;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int bad_we = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(8), .DATA_W(8), .MAX_BURST(4), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    // Behavioural dmem with a preload port used only by the bench.
    logic [7:0] mem [256];
    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'h00;
    logic [7:0] load_data = 8'h00;

    always @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        else if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // A RAM write must always come from the granted, requesting, writing port.
    always @(negedge clk) begin
        if (!rst && ram_we && !((gnt0 && req0 && we0) || (gnt1 && req1 && we1)))
            bad_we++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    task automatic checkint(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        logic       e1;
        logic [7:0] ea;

        // Requester inputs active during reset must have no effect.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h33; wdata0 = 8'hCC;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;

        // Preload RAM while reset is held.
        next_cycle();
        load_en = 1'b1; load_addr = 8'h10; load_data = 8'hA5;
        next_cycle();
        load_addr = 8'h20; load_data = 8'h5A;
        next_cycle();
        load_addr = 8'h50; load_data = 8'h77;
        next_cycle();
        load_en = 1'b0;
        sample();
        check1("rst_gnt0", gnt0, 1'b0);
        check1("rst_gnt1", gnt1, 1'b0);
        check1("rst_rvalid0", rvalid0, 1'b0);
        check1("rst_rvalid1", rvalid1, 1'b0);
        check1("rst_ram_we", ram_we, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check8("rst_ram_addr", ram_addr, 8'h00);
        check8("rst_ram_din", ram_din, 8'h00);
        check8("rst_rdata0", rdata0, 8'h00);
        check8("rst_rdata1", rdata1, 8'h00);

        // ---- 1: single read by port 0 ----
        next_cycle();
        rst = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        sample();                                   // cycle 0
        check1("t1_gnt0_c0", gnt0, 1'b0);
        check8("t1_addr_c0", ram_addr, 8'h00);
        next_cycle();
        sample();                                   // cycle 1: issue
        check1("t1_gnt0_c1", gnt0, 1'b1);
        check1("t1_busy_c1", busy, 1'b1);
        check8("t1_addr_c1", ram_addr, 8'h10);
        check1("t1_we_c1", ram_we, 1'b0);
        next_cycle();
        req0 = 1'b0;
        sample();                                   // cycle 2: data back
        check1("t1_rvalid0_c2", rvalid0, 1'b1);
        check8("t1_rdata0_c2", rdata0, 8'hA5);
        check1("t1_rvalid1_c2", rvalid1, 1'b0);
        check8("t1_addr_c2", ram_addr, 8'h00);
        next_cycle();
        sample();                                   // cycle 3: idle
        check1("t1_busy_c3", busy, 1'b0);
        check1("t1_gnt0_c3", gnt0, 1'b0);
        check1("t1_rvalid0_c3", rvalid0, 1'b0);

        // ---- 2: simultaneous requests after reset ----
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h10; addr1 = 8'h10;
        sample();                                   // cycle 0
        check1("t2_gnt0_c0", gnt0, 1'b0);
        check1("t2_gnt1_c0", gnt1, 1'b0);
        next_cycle();
        sample();                                   // cycle 1: port 0 wins
        check1("t2_gnt0_c1", gnt0, 1'b1);
        check1("t2_gnt1_c1", gnt1, 1'b0);
        next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        sample();                                   // cycle 2
        check1("t2_rvalid0_c2", rvalid0, 1'b1);
        check8("t2_rdata0_c2", rdata0, 8'hA5);
        next_cycle();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 8'h30; wdata0 = 8'h3C; addr1 = 8'h31; wdata1 = 8'h1D;
        sample();                                   // cycle 3: idle again
        check1("t2_busy_c3", busy, 1'b0);

        // ---- 3/4: continuous writes, alternating 4-access tenures ----
        // Port 1 goes first (last=0). Port 0's final access in its second
        // tenure (i==15) is a read of 0x20.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            if (i == 15) begin
                we0 = 1'b0; addr0 = 8'h20;
            end
            sample();
            e1 = (i < 4) || (i >= 8 && i < 12);
            ea = e1 ? 8'h31 : ((i == 15) ? 8'h20 : 8'h30);
            check1($sformatf("t3_gnt1_%0d", i), gnt1, e1);
            check1($sformatf("t3_gnt0_%0d", i), gnt0, !e1);
            check1($sformatf("t3_we_%0d", i), ram_we, (i == 15) ? 1'b0 : 1'b1);
            check8($sformatf("t3_addr_%0d", i), ram_addr, ea);
        end
        next_cycle();
        sample();                                   // port 1 owns, port 0 data returns
        check1("t4_gnt1", gnt1, 1'b1);
        check1("t4_rvalid0", rvalid0, 1'b1);
        check8("t4_rdata0", rdata0, 8'h5A);
        check1("t4_rvalid1", rvalid1, 1'b0);
        check8("t4_rdata1", rdata1, 8'h00);

        // ---- 5: non-owner write attempt to 0x50 ----
        next_cycle();
        req1 = 1'b0; we1 = 1'b1; addr1 = 8'h50; wdata1 = 8'hEE;
        we0 = 1'b0; addr0 = 8'h50;
        sample();                                   // port 1 still granted, no req
        check1("t5_gnt1_a", gnt1, 1'b1);
        check1("t5_we_a", ram_we, 1'b0);
        next_cycle();
        sample();                                   // port 0 reads 0x50
        check1("t5_gnt0_b", gnt0, 1'b1);
        check1("t5_we_b", ram_we, 1'b0);
        check8("t5_addr_b", ram_addr, 8'h50);
        next_cycle();
        sample();                                   // second read of 0x50
        check1("t5_rvalid0_c", rvalid0, 1'b1);
        check8("t5_rdata0_c", rdata0, 8'h77);
        check1("t5_we_c", ram_we, 1'b0);
        next_cycle();
        req0 = 1'b0;
        sample();
        check1("t5_rvalid0_d", rvalid0, 1'b1);
        check8("t5_rdata0_d", rdata0, 8'h77);
        check1("t5_rvalid1_d", rvalid1, 1'b0);
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        we1 = 1'b0;
        sample();
        check1("t5_busy_e", busy, 1'b0);

        // ---- 6: reset mid-burst with a read in flight ----
        next_cycle();
        sample();                                   // first read
        check1("t6_gnt0_a", gnt0, 1'b1);
        next_cycle();
        sample();                                   // second read, first returns
        check1("t6_gnt0_b", gnt0, 1'b1);
        check1("t6_rvalid0_b", rvalid0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("t6_gnt0_rst", gnt0, 1'b0);
        check1("t6_busy_rst", busy, 1'b0);
        check1("t6_rvalid0_rst", rvalid0, 1'b0);
        check8("t6_rdata0_rst", rdata0, 8'h00);
        check1("t6_we_rst", ram_we, 1'b0);
        check8("t6_addr_rst", ram_addr, 8'h00);
        next_cycle();
        check1("t6_rvalid0_held", rvalid0, 1'b0);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h10; addr1 = 8'h10;
        sample();                                   // cycle 0 after release
        check1("t6_rvalid0_r0", rvalid0, 1'b0);
        check1("t6_gnt0_r0", gnt0, 1'b0);
        next_cycle();
        sample();                                   // port 0 wins again
        check1("t6_gnt0_r1", gnt0, 1'b1);
        check1("t6_gnt1_r1", gnt1, 1'b0);
        check1("t6_rvalid0_r1", rvalid0, 1'b0);
        next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        sample();
        check1("t6_rvalid0_r2", rvalid0, 1'b1);
        check8("t6_rdata0_r2", rdata0, 8'hA5);
        next_cycle();
        sample();

        checkint("we_owner", bad_we, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
